// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared TAP state encoding, op codes and the TAP transition
//               table used by the JTAG initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int c_MAX_LEN           = 32;
    localparam int c_LEN_W             = 6;
    localparam int c_RESET_TMS_CYCLES  = 5;

    localparam logic [1:0] c_OP_DR     = 2'd0;
    localparam logic [1:0] c_OP_IR     = 2'd1;
    localparam logic [1:0] c_OP_RESET  = 2'd2;
    localparam logic [1:0] c_OP_NOP    = 2'd3;

    typedef enum logic [3:0] {
        TAP_TLR       = 4'd0,
        TAP_RTI       = 4'd1,
        TAP_SEL_DR    = 4'd2,
        TAP_CAP_DR    = 4'd3,
        TAP_SHIFT_DR  = 4'd4,
        TAP_EXIT1_DR  = 4'd5,
        TAP_PAUSE_DR  = 4'd6,
        TAP_EXIT2_DR  = 4'd7,
        TAP_UPDATE_DR = 4'd8,
        TAP_SEL_IR    = 4'd9,
        TAP_CAP_IR    = 4'd10,
        TAP_SHIFT_IR  = 4'd11,
        TAP_EXIT1_IR  = 4'd12,
        TAP_PAUSE_IR  = 4'd13,
        TAP_EXIT2_IR  = 4'd14,
        TAP_UPDATE_IR = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } op_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TAP_TLR:       n = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    n = tms ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    n = tms ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: n = tms ? TAP_SEL_DR    : TAP_RTI;
            default:       n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tap_state_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tap_state_tracker
// Description : Shadow copy of the target TAP state machine, advanced by the
//               TMS value driven during the preceding cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_state_tracker
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] STATE
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_comb begin
        w_next = tap_next(r_state, TMS);
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign STATE = r_state;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_driver.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_driver
// Description : JTAG initiator; sequences TMS for DR/IR scans and TAP reset,
//               shifts TDI LSB first and captures TDO into the response.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_driver
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN,
    parameter int LEN_W   = c_LEN_W
) (
    input  logic               TCLK,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic [3:0]         STATE
);

    op_state_t          r_fsm;
    op_state_t          w_fsm_nxt;
    logic [1:0]         r_op;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [MAX_LEN-1:0] r_shift;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp_data;

    logic [3:0]         w_state;
    tap_state_t         w_tap;
    logic               w_tms;
    logic               w_accept;
    logic               w_cmd_is_scan;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_shifting;
    logic               w_last_bit;
    logic               w_done;

    tap_state_tracker u_tracker (
        .TCLK  (TCLK),
        .TRST  (TRST),
        .TMS   (w_tms),
        .STATE (w_state)
    );

    assign w_tap = tap_state_t'(w_state);

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_cmd_is_scan = (cmd_op != c_OP_RESET) && (cmd_op != c_OP_NOP);
    assign w_len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    assign w_shifting = (r_fsm == S_ACTIVE) &&
                        ((w_tap == TAP_SHIFT_DR) || (w_tap == TAP_SHIFT_IR));
    assign w_last_bit = (r_cnt == (r_len - LEN_W'(1)));

    // Non-reset ops with r_len==0 (NOP or empty scan) finish after one cycle.
    always_comb begin
        w_done = 1'b0;
        if (r_fsm == S_ACTIVE) begin
            if (r_op == c_OP_RESET) begin
                w_done = (r_cnt == LEN_W'(c_RESET_TMS_CYCLES));
            end else if (r_len == '0) begin
                w_done = 1'b1;
            end else begin
                w_done = (w_tap == TAP_UPDATE_DR) || (w_tap == TAP_UPDATE_IR);
            end
        end
    end

    always_comb begin
        w_tms = 1'b0;
        if (r_fsm == S_ACTIVE) begin
            if (r_op == c_OP_RESET) begin
                w_tms = (r_cnt < LEN_W'(c_RESET_TMS_CYCLES));
            end else if (r_len != '0) begin
                case (w_tap)
                    TAP_RTI:      w_tms = 1'b1;
                    TAP_SEL_DR:   w_tms = (r_op == c_OP_IR);
                    TAP_SEL_IR:   w_tms = 1'b0;
                    TAP_CAP_DR,
                    TAP_CAP_IR:   w_tms = 1'b0;
                    TAP_SHIFT_DR,
                    TAP_SHIFT_IR: w_tms = w_last_bit;
                    TAP_EXIT1_DR,
                    TAP_EXIT1_IR: w_tms = 1'b1;
                    default:      w_tms = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE,
            S_RESP:   w_fsm_nxt = w_accept ? S_ACTIVE : S_IDLE;
            S_ACTIVE: if (w_done) w_fsm_nxt = S_RESP;
            default:  w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            r_fsm      <= S_IDLE;
            r_op       <= 2'd0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_cap      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_len   <= w_cmd_is_scan ? w_len_clamped : '0;
                r_cnt   <= '0;
                r_shift <= cmd_data;
                r_cap   <= '0;
            end else if (r_fsm == S_ACTIVE) begin
                if (r_op == c_OP_RESET) begin
                    r_cnt <= r_cnt + LEN_W'(1);
                end else if (w_shifting) begin
                    r_shift <= r_shift >> 1;
                    r_cap   <= r_cap | (MAX_LEN'(TDO) << r_cnt);
                    r_cnt   <= r_cnt + LEN_W'(1);
                end
                if (w_done) begin
                    r_rsp_data <= r_cap;
                end
            end
        end
    end

    assign cmd_ready = (r_fsm != S_ACTIVE) && (w_tap == TAP_RTI);
    assign TMS       = w_tms;
    assign TDI       = w_shifting ? r_shift[0] : 1'b0;
    assign rsp_valid = (r_fsm == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign STATE     = w_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_driver
// Description : Directed bench for jtag_tap_driver with a reference TAP model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_driver;

    logic        TCLK = 1'b0;
    logic        TRST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  STATE;

    logic [1:0]  tdo_mode;
    logic [3:0]  ref_state = 4'd0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 TCLK = ~TCLK;

    // 0: loopback TDI, 1: tied high, 2: tied low
    assign TDO = (tdo_mode == 2'd0) ? TDI : (tdo_mode == 2'd1);

    jtag_tap_driver #(.MAX_LEN(32), .LEN_W(6)) dut (
        .TCLK      (TCLK),
        .TRST      (TRST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .STATE     (STATE)
    );

    // Independent TAP controller model: {next when TMS=0, next when TMS=1}
    function automatic logic [3:0] tap_ref(input logic [3:0] s, input logic tms);
        logic [7:0] t;
        case (s)
            4'd0:  t = {4'd1, 4'd0};
            4'd1:  t = {4'd1, 4'd2};
            4'd2:  t = {4'd3, 4'd9};
            4'd3:  t = {4'd4, 4'd5};
            4'd4:  t = {4'd4, 4'd5};
            4'd5:  t = {4'd6, 4'd8};
            4'd6:  t = {4'd6, 4'd7};
            4'd7:  t = {4'd4, 4'd8};
            4'd8:  t = {4'd1, 4'd2};
            4'd9:  t = {4'd10, 4'd0};
            4'd10: t = {4'd11, 4'd12};
            4'd11: t = {4'd11, 4'd12};
            4'd12: t = {4'd13, 4'd15};
            4'd13: t = {4'd13, 4'd14};
            4'd14: t = {4'd11, 4'd15};
            default: t = {4'd1, 4'd2};
        endcase
        return tms ? t[3:0] : t[7:4];
    endfunction

    always @(posedge TCLK) begin
        ref_state <= TRST ? 4'd0 : tap_ref(ref_state, TMS);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge TCLK) begin
        if (mon_en) begin
            chk("shadow_vs_tap", 64'(STATE), 64'(ref_state));
            if (STATE != 4'd4 && STATE != 4'd11)
                chk("tdi_outside_shift", 64'(TDI), 64'd0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge TCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Records TMS per cycle until rsp_valid; returns latency in edges after E0.
    task automatic wait_rsp(output int lat, output logic [63:0] tms);
        lat = -1;
        tms = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge TCLK);
            if (rsp_valid) begin
                lat = k - 1;
                break;
            end
            if (k <= 64) tms[k-1] = TMS;
        end
        if (lat < 0) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic [1:0]  tdo;
        int          lat;
        logic [31:0] rsp;
        logic [63:0] tms;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int          lat;
    logic [63:0] tms;
    logic [3:0]  exp_states [7];

    initial begin
        vecs[0] = '{2'd0, 6'd8,  32'h0000_00A5, 2'd0, 13, 32'h0000_00A5, 64'h0C01};
        vecs[1] = '{2'd1, 6'd4,  32'h0000_0003, 2'd1, 10, 32'h0000_000F, 64'h0183};
        vecs[2] = '{2'd2, 6'd9,  32'hFFFF_FFFF, 2'd1, 6,  32'h0,         64'h001F};
        vecs[3] = '{2'd3, 6'd8,  32'hFFFF_FFFF, 2'd1, 1,  32'h0,         64'h0};
        vecs[4] = '{2'd0, 6'd0,  32'hFFFF_FFFF, 2'd1, 1,  32'h0,         64'h0};
        vecs[5] = '{2'd0, 6'd40, 32'hDEAD_BEEF, 2'd0, 37, 32'hDEAD_BEEF, 64'hC_0000_0001};
        vecs[6] = '{2'd0, 6'd1,  32'h0000_0001, 2'd2, 6,  32'h0,         64'h0019};
        vecs[7] = '{2'd1, 6'd5,  32'h0000_0015, 2'd0, 11, 32'h0000_0015, 64'h0303};
        vecs[8] = '{2'd0, 6'd12, 32'hFFFF_F123, 2'd0, 17, 32'h0000_0123, 64'hC001};

        TRST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = '0;
        cmd_data = '0; tdo_mode = 2'd0;
        repeat (2) @(posedge TCLK);
        @(negedge TCLK);
        chk("rst_state",     64'(STATE),     64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_tms",       64'(TMS),       64'd0);
        chk("rst_tdi",       64'(TDI),       64'd0);
        mon_en = 1'b1;
        TRST = 1'b0;
        @(negedge TCLK);
        chk("post_rst_state", 64'(STATE),     64'd1);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            tdo_mode = vecs[i].tdo;
            chk($sformatf("v%0d_ready", i), 64'(cmd_ready), 64'd1);
            issue(vecs[i].op, vecs[i].len, vecs[i].data);
            wait_rsp(lat, tms);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_tms", i), tms, vecs[i].tms);
            chk($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].rsp));
            chk($sformatf("v%0d_ready_in_rsp", i), 64'(cmd_ready), 64'd1);
            @(negedge TCLK);
            chk($sformatf("v%0d_rsp_pulse", i), 64'(rsp_valid), 64'd0);
            chk($sformatf("v%0d_rsp_hold", i), 64'(rsp_data), 64'(vecs[i].rsp));
        end

        // TAP reset op: shadow walk RTI,2,9,0,0,0 then back to RTI with response
        exp_states = '{4'd1, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd1};
        tdo_mode = 2'd1;
        issue(2'd2, 6'd0, 32'h0);
        for (int k = 0; k < 7; k++) begin
            @(negedge TCLK);
            chk($sformatf("rstop_state%0d", k), 64'(STATE), 64'(exp_states[k]));
        end
        chk("rstop_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rstop_rsp_data",  64'(rsp_data),  64'd0);
        @(negedge TCLK);

        // Back-to-back: second command accepted in the first's rsp_valid cycle
        tdo_mode = 2'd0;
        issue(2'd0, 6'd4, 32'h9);
        wait_rsp(lat, tms);
        chk("b2b_first_lat",  64'(lat),       64'd9);
        chk("b2b_first_rsp",  64'(rsp_data),  64'h9);
        chk("b2b_ready",      64'(cmd_ready), 64'd1);
        issue(2'd0, 6'd3, 32'h5);
        wait_rsp(lat, tms);
        chk("b2b_second_lat", 64'(lat),       64'd8);
        chk("b2b_second_rsp", 64'(rsp_data),  64'h5);
        @(negedge TCLK);

        // TRST in the middle of a 16-bit DR shift
        issue(2'd0, 6'd16, 32'hBEEF);
        repeat (6) @(negedge TCLK);
        chk("abort_in_shift", 64'(STATE), 64'd4);
        TRST = 1'b1;
        @(negedge TCLK);
        chk("abort_state",     64'(STATE),     64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_ready",     64'(cmd_ready), 64'd0);
        chk("abort_tms",       64'(TMS),       64'd0);
        TRST = 1'b0;
        @(negedge TCLK);
        chk("abort_rti",       64'(STATE),     64'd1);
        chk("abort_ready_back", 64'(cmd_ready), 64'd1);
        chk("abort_no_rsp",    64'(rsp_valid), 64'd0);
        issue(2'd0, 6'd8, 32'h3C);
        wait_rsp(lat, tms);
        chk("after_abort_lat", 64'(lat),      64'd13);
        chk("after_abort_rsp", 64'(rsp_data), 64'h3C);
        chk("after_abort_tms", tms,           64'h0C01);
        repeat (2) @(negedge TCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
